// File: rtl/proc_pkg.sv
// Encodings shared by the instruction store, its loader and the processor.
package proc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } store_state_t;

  // Transfer opcodes agreed between loaders and the processor.
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b11
  } opcode_t;

  localparam logic [7:0] NOP_INST = 8'h00;

endpackage

// File: rtl/inst_load_ctrl.sv
// Program-load sequencer: state machine, write pointer, running checksum and
// load handshake for the instruction store.
module inst_load_ctrl
  import proc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic [DATA_W-1:0] checksum,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output store_state_t      state
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr;

  // A restart on the same edge as a beat wins, so the byte is never written.
  assign load_ready = (state == LOAD);
  assign wr_en      = load_valid & load_ready & ~load_start;
  assign wr_addr    = wr_ptr;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      wr_ptr    <= '0;
      checksum  <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state    <= LOAD;
        wr_ptr   <= '0;
        checksum <= '0;
      end else if (wr_en) begin
        checksum <= checksum ^ load_data;
        wr_ptr   <= wr_ptr + 1'b1;
        if (wr_ptr == LAST) begin
          state     <= RUN;
          load_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_store.sv
// Loadable 8x8 instruction store; answers processor fetches with one cycle of
// latency and returns NOP whenever a valid program is not resident.
module inst_store
  import proc_pkg::*;
#(
  parameter int              DEPTH  = 8,
  parameter int              ADDR_W = 3,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] NOP  = NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  input  logic              load_start,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic [DATA_W-1:0] checksum
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  store_state_t      state;
  logic [DATA_W-1:0] mem [DEPTH];

  inst_load_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .checksum   (checksum),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .state      (state)
  );

  // NOTE: the array is reset because every entry must read back as NOP after
  // reset; this forces flops rather than a RAM macro, which is fine at 8 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
    end else if (wr_en) begin
      mem[wr_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= NOP;
      inst_valid  <= 1'b0;
    end else begin
      instruction <= (state == RUN) ? mem[address] : NOP;
      inst_valid  <= (state == RUN);
    end
  end

endmodule

// File: tb/tb_inst_store.sv
// Directed bench for inst_store: reset, loads, aborts, restarts and fetches.
module tb_inst_store;

  typedef logic [7:0] prog_t [8];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] address;
  logic [7:0] instruction;
  logic       inst_valid;
  logic       load_start;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       load_done;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;

  inst_store dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .load_start  (load_start),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Issue a single-cycle load_start with no data.
  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    check("ready_after_start", load_ready, 1);
  endtask

  // Stream all eight bytes (optionally every other cycle) from the current
  // negedge; address is held at 3 so masking and first valid read are checked.
  task automatic run_beats(input prog_t prog, input bit toggle, input logic [7:0] exp_sum);
    int  cyc  = 1;
    int  idx  = 0;
    bit  done = 0;
    address = 3'd3;
    while (!done && cyc < 40) begin
      load_valid = (idx < 8) && (!toggle || ((cyc - 1) % 2 == 0));
      load_data  = (idx < 8) ? prog[idx] : 8'h00;
      if (load_valid) idx++;
      @(negedge clk);
      cyc++;
      check("masked_instr", instruction, 8'h00);
      check("masked_valid", inst_valid, 0);
      if (load_done) done = 1;
    end
    load_valid = 1'b0;
    check("done_seen", done, 1);
    check("done_cycle", cyc, toggle ? 16 : 9);
    check("checksum", checksum, exp_sum);
    check("ready_in_run", load_ready, 0);
    @(negedge clk);
    check("done_one_pulse", load_done, 0);
    check("first_read", instruction, prog[3]);
    check("first_read_valid", inst_valid, 1);
  endtask

  task automatic read_at(input logic [2:0] a, input logic [7:0] exp, input logic exp_v);
    address = a;
    @(negedge clk);
    check("read_instr", instruction, exp);
    check("read_valid", inst_valid, exp_v);
  endtask

  task automatic read_all(input prog_t exp, input logic exp_v);
    for (int a = 0; a < 8; a++) read_at(3'(a), exp[a], exp_v);
  endtask

  prog_t prog1 = '{8'hC1, 8'h01, 8'hC6, 8'h02, 8'hC3, 8'h00, 8'h03, 8'h02};
  prog_t prog5a = '{default: 8'h5A};
  prog_t prog_nop = '{default: 8'h00};

  initial begin
    rst_n      = 1'b0;
    address    = 3'd0;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;

    // Reset held with junk on the load port.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_instr", instruction, 8'h00);
      check("rst_valid", inst_valid, 0);
      check("rst_ready", load_ready, 0);
    end
    check("rst_done", load_done, 0);
    check("rst_sum", checksum, 8'h00);
    rst_n = 1'b1;

    // load_valid in EMPTY must be ignored.
    repeat (3) @(negedge clk);
    check("empty_ready", load_ready, 0);
    check("empty_sum", checksum, 8'h00);
    load_valid = 1'b0;

    // Back-to-back load, then reads in order and out of order.
    start_load();
    run_beats(prog1, 1'b0, 8'hC6);
    read_all(prog1, 1'b1);
    read_at(3'd5, 8'h00, 1'b1);
    read_at(3'd2, 8'hC6, 1'b1);
    read_at(3'd7, 8'h02, 1'b1);
    read_at(3'd0, 8'hC1, 1'b1);
    check("run_sum_hold", checksum, 8'hC6);

    // Same program, load_valid toggling.
    start_load();
    run_beats(prog1, 1'b1, 8'hC6);
    read_all(prog1, 1'b1);

    // Abort after three beats with restart and a beat on the same edge.
    start_load();
    load_valid = 1'b1; load_data = 8'hAA; @(negedge clk);
    load_data = 8'hBB; @(negedge clk);
    load_data = 8'hCC; @(negedge clk);
    check("abort_partial_sum", checksum, 8'hAA ^ 8'hBB ^ 8'hCC);
    load_start = 1'b1; load_data = 8'h11;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0;
    check("abort_sum_clear", checksum, 8'h00);
    check("abort_ready", load_ready, 1);
    check("abort_no_done", load_done, 0);
    run_beats(prog5a, 1'b0, 8'h00);
    read_all(prog5a, 1'b1);

    // Restart on the same edge as the final beat: no RUN, no load_done.
    start_load();
    load_valid = 1'b1; load_data = 8'h33;
    repeat (7) @(negedge clk);
    load_start = 1'b1; load_data = 8'h44;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0;
    check("final_restart_no_done", load_done, 0);
    check("final_restart_ready", load_ready, 1);
    check("final_restart_sum", checksum, 8'h00);
    @(negedge clk);
    check("final_restart_masked", inst_valid, 0);
    run_beats(prog1, 1'b0, 8'hC6);
    read_all(prog1, 1'b1);

    // Asynchronous reset in the middle of a load.
    start_load();
    load_valid = 1'b1; load_data = 8'h77;
    repeat (5) @(negedge clk);
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", load_ready, 0);
    check("async_sum", checksum, 8'h00);
    check("async_instr", instruction, 8'h00);
    check("async_valid", inst_valid, 0);
    check("async_done", load_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    read_all(prog_nop, 1'b0);
    start_load();
    run_beats(prog1, 1'b0, 8'hC6);
    read_all(prog1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
